// File: rtl/njesia_kontrollit_mc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALUOp codes,
// FSM state encoding and PCSrc encoding.
package njesia_kontrollit_mc_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_SLTI  = 4'b0001;
   localparam logic [3:0] OP_ADDI  = 4'b0010;
   localparam logic [3:0] OP_LW    = 4'b0100;
   localparam logic [3:0] OP_SW    = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b1000;
   localparam logic [3:0] OP_J     = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [3:0] ALU_ALU16 = 4'b0000;
   localparam logic [3:0] ALU_SLTI  = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0011;
   localparam logic [3:0] ALU_SLL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_STOP
   } state_t;

   // Opcodes that proceed from DECODE into EXEC; HALT and undefined ones stop.
   function automatic logic is_exec_opcode(input logic [3:0] op);
      return (op == OP_RTYPE) || (op == OP_SLTI) || (op == OP_ADDI) ||
             (op == OP_LW)    || (op == OP_SW)   || (op == OP_BEQ)  ||
             (op == OP_J);
   endfunction

endpackage

// File: rtl/njesia_kontrollit_mc_dekoderi_alu.sv
// Combinational opcode/funct to ALUOp and ALUSrcB mapping used in EXEC, MEM and WB.
module dekoderi_alu
   import njesia_kontrollit_mc_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [3:0] funct,
   output logic [3:0] alu_op,
   output logic       alu_src_b
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch is inferred.
      alu_op    = ALU_ALU16;
      alu_src_b = 1'b0;
      case (opcode)
         OP_RTYPE: alu_op = funct;
         OP_SLTI: begin
            alu_op    = ALU_SLTI;
            alu_src_b = 1'b1;
         end
         OP_ADDI, OP_LW, OP_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
         end
         OP_BEQ:  alu_op = ALU_SUB;
         default: ;
      endcase
   end

endmodule

// File: rtl/njesia_kontrollit_mc.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/STOP) for the 16-bit CPU.
// Optional retired-instruction counter when KONTROLLI_INSTR_COUNT_EN is defined.
module njesia_kontrollit_mc
   import njesia_kontrollit_mc_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] Instr,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        MemReq,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic [3:0]  ALUOp,
   output logic        ALUSrcB,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        RegDst,
   output logic        Halted,
   output logic        Illegal
`ifdef KONTROLLI_INSTR_COUNT_EN
   ,
   output logic [15:0] InstrCount
`endif
);

   state_t     state, state_next;
   logic       halted_q, illegal_q;
   logic [3:0] opcode, funct;
   logic [3:0] dec_alu_op;
   logic       dec_alu_src_b;
   logic       instr_unused;

   assign opcode       = Instr[15:12];
   assign funct        = Instr[3:0];
   assign instr_unused = ^Instr[11:4];

   dekoderi_alu u_dekoderi_alu (
      .opcode    (opcode),
      .funct     (funct),
      .alu_op    (dec_alu_op),
      .alu_src_b (dec_alu_src_b)
   );

   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      if (Reset) begin
         state     <= S_FETCH;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE && state_next == S_STOP) begin
            if (opcode == OP_HALT) halted_q  <= 1'b1;
            else                   illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = PC_SEQ;
      ALUOp      = ALU_ALU16;
      ALUSrcB    = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = 1'b0;
      RegDst     = 1'b0;
      Halted     = halted_q;
      Illegal    = illegal_q;

      case (state)
         S_FETCH: begin
            MemReq = 1'b1;
            if (MemReady) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: state_next = is_exec_opcode(opcode) ? S_EXEC : S_STOP;
         S_EXEC: begin
            ALUOp   = dec_alu_op;
            ALUSrcB = dec_alu_src_b;
            case (opcode)
               OP_BEQ: begin
                  PCWrite    = Zero;
                  PCSrc      = PC_BRANCH;
                  state_next = S_FETCH;
               end
               OP_J: begin
                  PCWrite    = 1'b1;
                  PCSrc      = PC_JUMP;
                  state_next = S_FETCH;
               end
               OP_LW, OP_SW: state_next = S_MEM;
               default:      state_next = S_WB;
            endcase
         end
         S_MEM: begin
            MemReq   = 1'b1;
            MemWrite = (opcode == OP_SW);
            ALUOp    = dec_alu_op;
            ALUSrcB  = dec_alu_src_b;
            if (MemReady) state_next = (opcode == OP_SW) ? S_FETCH : S_WB;
         end
         S_WB: begin
            RegWrite   = 1'b1;
            ALUOp      = dec_alu_op;
            ALUSrcB    = dec_alu_src_b;
            RegDst     = (opcode == OP_RTYPE);
            MemToReg   = (opcode == OP_LW);
            state_next = S_FETCH;
         end
         default: ;
      endcase

      // Outputs are forced quiet for as long as Reset is held, not just after the edge.
      if (Reset) begin
         MemReq   = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = PC_SEQ;
         ALUOp    = ALU_ALU16;
         ALUSrcB  = 1'b0;
         RegWrite = 1'b0;
         MemToReg = 1'b0;
         RegDst   = 1'b0;
         Halted   = 1'b0;
         Illegal  = 1'b0;
      end
   end

`ifdef KONTROLLI_INSTR_COUNT_EN
   logic [15:0] count_q;
   logic        retire;

   assign retire = (state_next == S_FETCH) &&
                   (state == S_EXEC || state == S_MEM || state == S_WB);

   always_ff @(posedge Clock) begin
      if (Reset)       count_q <= 16'h0000;
      else if (retire) count_q <= count_q + 16'h0001;
   end

   assign InstrCount = Reset ? 16'h0000 : count_q;
`endif

endmodule

// File: tb/tb_njesia_kontrollit_mc.sv
// Directed self-checking bench for njesia_kontrollit_mc; InstrCount checks are
// active only when KONTROLLI_INSTR_COUNT_EN is defined.
module tb_njesia_kontrollit_mc;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] Instr;
   logic        Zero;
   logic        MemReady;
   logic        MemReq, MemWrite, IRWrite, PCWrite;
   logic [1:0]  PCSrc;
   logic [3:0]  ALUOp;
   logic        ALUSrcB, RegWrite, MemToReg, RegDst, Halted, Illegal;
`ifdef KONTROLLI_INSTR_COUNT_EN
   logic [15:0] InstrCount;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] outs;
   assign outs = {MemReq, MemWrite, IRWrite, PCWrite, PCSrc, ALUOp,
                  ALUSrcB, RegWrite, MemToReg, RegDst, Halted, Illegal};

   njesia_kontrollit_mc dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Instr      (Instr),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .PCSrc      (PCSrc),
      .ALUOp      (ALUOp),
      .ALUSrcB    (ALUSrcB),
      .RegWrite   (RegWrite),
      .MemToReg   (MemToReg),
      .RegDst     (RegDst),
      .Halted     (Halted),
      .Illegal    (Illegal)
`ifdef KONTROLLI_INSTR_COUNT_EN
      ,
      .InstrCount (InstrCount)
`endif
   );

   always #5 Clock = ~Clock;

   // Expected output bundle, same bit order as outs.
   function automatic logic [15:0] e(input logic mr, mw, ir, pw,
                                     input logic [1:0] ps,
                                     input logic [3:0] op,
                                     input logic sb, rw, m2r, rd, h, il);
      return {mr, mw, ir, pw, ps, op, sb, rw, m2r, rd, h, il};
   endfunction

   task automatic step();
      @(posedge Clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] expected);
      #1;
      n_tests++;
      assert (outs === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, outs, expected);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] expected);
`ifdef KONTROLLI_INSTR_COUNT_EN
      n_tests++;
      assert (InstrCount === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, InstrCount, expected);
      end
`else
      if (expected === 16'hxxxx) $display("[TB] %s unused", tag);
`endif
   endtask

   logic [15:0] fetch_go, fetch_wait;

   initial begin
      fetch_go   = e(1,0,1,1,2'd0,4'h0,0,0,0,0,0,0);
      fetch_wait = e(1,0,0,0,2'd0,4'h0,0,0,0,0,0,0);

      Reset = 1'b1; Instr = 16'h0000; Zero = 1'b0; MemReady = 1'b0;
      chk("reset_t0", 16'h0000);
      step; step;
      MemReady = 1'b1;
      chk("reset_held", 16'h0000);
      chk_cnt("reset_cnt", 16'd0);

      // First cycle after reset release is FETCH.
      Reset = 1'b0; MemReady = 1'b0; Instr = 16'h0126;
      chk("fetch_wait", fetch_wait);

      // R-type SLL, zero wait states.
      MemReady = 1'b1;
      chk("rt_fetch", fetch_go);
      step; chk("rt_decode", 16'h0000);
      step; chk("rt_exec", e(0,0,0,0,2'd0,4'h6,0,0,0,0,0,0));
      step; chk("rt_wb",   e(0,0,0,0,2'd0,4'h6,0,1,0,1,0,0));
      step; Instr = 16'h4123;
      chk("rt_refetch", fetch_go);
      chk_cnt("rt_cnt", 16'd1);

      // LW with two memory wait cycles.
      step; chk("lw_decode", 16'h0000);
      MemReady = 1'b0;
      step; chk("lw_exec",  e(0,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; chk("lw_mem_w1", e(1,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; chk("lw_mem_w2", e(1,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; MemReady = 1'b1;
      chk("lw_mem_rdy", e(1,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; chk("lw_wb",    e(0,0,0,0,2'd0,4'h2,1,1,1,0,0,0));
      step; Instr = 16'h8123; Zero = 1'b1;
      chk("lw_refetch", fetch_go);
      chk_cnt("lw_cnt", 16'd2);

      // BEQ taken, then not taken.
      step; step;
      chk("beq_t_exec", e(0,0,0,1,2'd1,4'h3,0,0,0,0,0,0));
      step; Zero = 1'b0;
      chk("beq_t_refetch", fetch_go);
      step; step;
      chk("beq_nt_exec", e(0,0,0,0,2'd1,4'h3,0,0,0,0,0,0));
      step; Instr = 16'hC123;
      chk("beq_nt_refetch", fetch_go);
      chk_cnt("beq_cnt", 16'd4);

      // J.
      step; step;
      chk("j_exec", e(0,0,0,1,2'd2,4'h0,0,0,0,0,0,0));
      step; Instr = 16'h5123;
      chk("j_refetch", fetch_go);

      // SW, zero wait states.
      step; step;
      chk("sw_exec", e(0,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; chk("sw_mem", e(1,1,0,0,2'd0,4'h2,1,0,0,0,0,0));
      step; Instr = 16'h1123;
      chk("sw_refetch", fetch_go);
      chk_cnt("sw_cnt", 16'd6);

      // SLTI.
      step; step;
      chk("slti_exec", e(0,0,0,0,2'd0,4'h1,1,0,0,0,0,0));
      step; chk("slti_wb", e(0,0,0,0,2'd0,4'h1,1,1,0,0,0,0));
      step; Instr = 16'h4123;
      chk("slti_refetch", fetch_go);
      chk_cnt("slti_cnt", 16'd7);

      // Reset while an LW waits in MEM.
      step; MemReady = 1'b0;
      step; step;
      chk("rst_lw_mem", e(1,0,0,0,2'd0,4'h2,1,0,0,0,0,0));
      Reset = 1'b1;
      chk("rst_mid_zero", 16'h0000);
      chk_cnt("rst_mid_cnt", 16'd0);
      step; chk("rst_next", 16'h0000);
      Reset = 1'b0;
      chk("rst_fetch", fetch_wait);
      chk_cnt("rst_cnt_clr", 16'd0);

      // Undefined opcode 0011 -> sticky Illegal, everything else idle.
      Instr = 16'h3000; MemReady = 1'b1;
      step; chk("ill_decode", 16'h0000);
      step; chk("ill_stop", e(0,0,0,0,2'd0,4'h0,0,0,0,0,0,1));
      for (int i = 0; i < 10; i++) begin
         step; MemReady = i[0];
         chk("ill_hold", e(0,0,0,0,2'd0,4'h0,0,0,0,0,0,1));
      end

      // HALT after a fresh reset -> sticky Halted.
      Reset = 1'b1;
      step; Reset = 1'b0; Instr = 16'hF000; MemReady = 1'b1;
      chk("halt_fetch", fetch_go);
      step; chk("halt_decode", 16'h0000);
      step; chk("halt_stop", e(0,0,0,0,2'd0,4'h0,0,0,0,0,1,0));
      for (int i = 0; i < 10; i++) begin
         step; MemReady = ~i[0];
         chk("halt_hold", e(0,0,0,0,2'd0,4'h0,0,0,0,0,1,0));
      end
      chk_cnt("halt_cnt", 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
